// File: rtl/mips_pkg.sv
// Shared types and default sizes for the MIPS register file slice.
package mips_pkg;

   typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

   localparam int MIPS_DATA_W = 32;
   localparam int MIPS_ADDR_W = 5;

endpackage

// File: rtl/mips_regfile_clr_ctrl.sv
// Bulk-clear sequencer: sweeps every register address once after reset or a clear request.
module mips_regfile_clr_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_W = MIPS_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   rf_state_t         state;
   logic [ADDR_W-1:0] cnt;

   assign clr_addr = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RF_CLEAR;
         cnt    <= '0;
         busy   <= 1'b1;
         clr_we <= 1'b1;
      end else begin
         case (state)
            RF_CLEAR: begin
               // Leave on the last address so the counter never wraps.
               if (cnt == '1) begin
                  state  <= RF_IDLE;
                  cnt    <= '0;
                  busy   <= 1'b0;
                  clr_we <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RF_IDLE: begin
               if (clr) begin
                  state  <= RF_CLEAR;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  clr_we <= 1'b1;
               end
            end
            default: begin
               state  <= RF_CLEAR;
               cnt    <= '0;
               busy   <= 1'b1;
               clr_we <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/mips_regfile_ext.sv
// Parametrised MIPS register file: two registered read ports, optional bypass,
// optional hard-wired zero register, and a sequential bulk clear.
module mips_regfile_ext
   import mips_pkg::*;
#(
   parameter int DATA_W   = MIPS_DATA_W,
   parameter int ADDR_W   = MIPS_ADDR_W,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd1_addr,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              user_ok;
   logic              wr_ok;
   logic [DATA_W-1:0] rd1_next;
   logic [DATA_W-1:0] rd2_next;

   mips_regfile_clr_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_clr_ctrl (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // User traffic only counts in IDLE and not on the edge a clear is accepted.
   assign user_ok = ~busy & ~clr;
   assign wr_ok   = wr_en & user_ok & ~(ZERO_REG && (wr_addr == '0));

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      if (ZERO_REG && (addr == '0))
         return '0;
      else if (BYPASS && wr_en && (wr_addr == addr))
         return wr_data;
      else
         return regs[addr];
   endfunction

   always_comb begin
      rd1_next = read_port(rd1_addr);
      rd2_next = read_port(rd2_addr);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we)
            regs[clr_addr] <= '0;
         else if (wr_ok)
            regs[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !user_ok) begin
         rd1_data <= '0;
         rd2_data <= '0;
      end else if (rd_en) begin
         rd1_data <= rd1_next;
         rd2_data <= rd2_next;
      end
   end

endmodule
